seq_rec_param: RTL and testbench
================================

SEQ_REC_PARAM -- requirements
Module: seq_rec_param

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8, giving the maximum pattern length in bits (legal range 2..16).
REQ-002 SHALL have parameter CNT_W, default 8, giving the match counter width.
REQ-003 SHALL have parameter DEF_PAT, default 8'b00000101, giving the pattern loaded at reset (MAX_LEN bits wide).
REQ-004 SHALL have parameter DEF_LEN, default 3, giving the pattern length loaded at reset.
REQ-005 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port nRESET, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port X, input, 1 bit: serial data bit.
REQ-008 SHALL have port X_VALID, input, 1 bit: X is sampled only when this is high.
REQ-009 SHALL have port CFG_WE, input, 1 bit: load-configuration strobe.
REQ-010 SHALL have port CFG_PAT, input, MAX_LEN bits: pattern, where bit LEN-1 is the first bit received and bit 0 is the last.
REQ-011 SHALL have port CFG_LEN, input, 5 bits: pattern length.
REQ-012 SHALL have port CFG_OVL, input, 1 bit: 1 = overlapping detection, 0 = non-overlapping.
REQ-013 SHALL have port CNT_CLR, input, 1 bit: synchronous clear of the match counter.
REQ-014 SHALL have port Z, output, 1 bit: registered one-cycle match pulse.
REQ-015 SHALL have port MATCH_CNT, output, CNT_W bits: saturating count of matches.
REQ-016 SHALL have port CNT_SAT, output, 1 bit: high while MATCH_CNT is all ones.

Function
REQ-017 SHALL hold the registers PAT, LEN, OVL, a MAX_LEN-bit history shift register HIST, and a fill counter FILL (0..MAX_LEN).
REQ-018 Valid sample (X_VALID=1, CFG_WE=0): SHALL shift HIST left with X entering bit 0, and SHALL set FILL to min(FILL+1, MAX_LEN).
REQ-019 Match condition SHALL be: after the shift, FILL >= LEN, LEN >= 1, and HIST[LEN-1:0] == PAT[LEN-1:0].
REQ-020 Z SHALL go high for exactly one cycle, in the cycle after the edge that sampled the completing bit (latency 1), and SHALL be 0 in all other cycles.
REQ-021 OVL=1: FILL SHALL be unaffected by a match, so a pattern suffix may begin the next match.
REQ-022 OVL=0: FILL SHALL be set to 0 on a match, so no bit is shared between matches.
REQ-023 X_VALID=0: HIST, FILL and MATCH_CNT SHALL hold, and Z SHALL be 0.
REQ-024 CFG_WE=1: SHALL load PAT, LEN and OVL, set FILL to 0, set Z to 0, and ignore X that cycle; MATCH_CNT SHALL be unchanged.
REQ-025 LEN effective value: CFG_LEN > MAX_LEN SHALL be stored as MAX_LEN; CFG_LEN = 0 SHALL disable matching (Z is never asserted).
REQ-026 Match counter: SHALL increment on each match and saturate at 2^CNT_W-1; CNT_SAT SHALL be asserted combinationally from MATCH_CNT.
REQ-027 CNT_CLR: SHALL set MATCH_CNT to 0; when CNT_CLR and a match occur in the same cycle, MATCH_CNT SHALL become 1.
REQ-028 HIST bits above LEN-1 SHALL be ignored in the comparison.

Reset
REQ-029 nRESET low SHALL immediately, without waiting for a clock edge, set HIST=0, FILL=0, Z=0, MATCH_CNT=0, PAT=DEF_PAT, LEN=DEF_LEN and OVL=1.
REQ-030 Reset asserted in the middle of a partial match SHALL discard all history; the first post-reset match SHALL require LEN fresh valid bits.
REQ-031 The first rising edge after nRESET deasserts SHALL operate normally.

Verification
REQ-032 Default configuration (101, LEN 3, OVL=1), one valid bit per clock, stream 1,1,0,0,1,1,0,1,1,0,1,0,1 -> Z pulses after bits 8, 11 and 13; MATCH_CNT=3.
REQ-033 Same stream after CFG_WE with CFG_OVL=0, PAT=101, LEN=3 -> Z pulses after bits 8 and 11 only; MATCH_CNT=2.
REQ-034 CFG_PAT=8'b11010010 with LEN=8, stream 1,1,0,1,0,0,1,0 with X_VALID deasserted for 3 cycles between bits 4 and 5 -> a single Z pulse after bit 8; no Z during the gap.
REQ-035 CNT_W=2 with 5 matches -> MATCH_CNT stops at 3 and CNT_SAT=1; CNT_CLR asserted on a match cycle -> MATCH_CNT=1 and CNT_SAT=0.
REQ-036 Reset asserted asynchronously mid-clock after bits 1,0 of 101 -> Z=0 and MATCH_CNT=0 immediately; a following single 1 -> no Z; then 1,0,1 -> Z.
REQ-037 CFG_LEN=0 with any stream -> Z is never asserted; CFG_LEN=20 -> LEN reads as MAX_LEN and MAX_LEN-bit matching is performed.

Source files
------------

// File: rtl/seq_rec_param.sv
`default_nettype none
// ============================================================================
// seq_rec_param : runtime-configurable serial pattern recogniser, match counter
// Rev 1.0
// ============================================================================
module seq_rec_param #(
  parameter int                 MAX_LEN = 8,
  parameter int                 CNT_W   = 8,
  parameter logic [MAX_LEN-1:0] DEF_PAT = MAX_LEN'(8'b00000101),
  parameter int                 DEF_LEN = 3
) (
  input  logic               CLK,
  input  logic               nRESET,
  input  logic               X,
  input  logic               X_VALID,
  input  logic               CFG_WE,
  input  logic [MAX_LEN-1:0] CFG_PAT,
  input  logic [4:0]         CFG_LEN,
  input  logic               CFG_OVL,
  input  logic               CNT_CLR,
  output logic               Z,
  output logic [CNT_W-1:0]   MATCH_CNT,
  output logic               CNT_SAT
);

  localparam logic [4:0]       C_MAX_LEN = 5'(MAX_LEN);
  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [4:0]         len_q, len_d;
  logic [4:0]         fill_q, fill_d;
  logic               ovl_q, ovl_d;
  logic               z_q, z_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [MAX_LEN-1:0] hist_shift;
  logic [MAX_LEN-1:0] len_mask;
  logic [4:0]         fill_inc;
  logic               sample;
  logic               match;

  // Match is evaluated on the post-shift history; only the low LEN bits count.
  always_comb begin
    sample     = X_VALID & ~CFG_WE;
    hist_shift = {hist_q[MAX_LEN-2:0], X};
    fill_inc   = (fill_q >= C_MAX_LEN) ? C_MAX_LEN : fill_q + 5'd1;
    len_mask   = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (5'(i) < len_q);
    end
    match = sample && (len_q != 5'd0) && (fill_inc >= len_q) &&
            (((hist_shift ^ pat_q) & len_mask) == '0);
  end

  always_comb begin
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    hist_d = hist_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
    z_d    = match;
    if (CFG_WE) begin
      pat_d  = CFG_PAT;
      len_d  = (CFG_LEN > C_MAX_LEN) ? C_MAX_LEN : CFG_LEN;
      ovl_d  = CFG_OVL;
      fill_d = 5'd0;
    end else if (X_VALID) begin
      hist_d = hist_shift;
      fill_d = (match && !ovl_q) ? 5'd0 : fill_inc;
    end
    // A clear coinciding with a match leaves that match counted.
    if (CNT_CLR) begin
      cnt_d = match ? C_CNT_ONE : '0;
    end else if (match && (cnt_q != C_CNT_MAX)) begin
      cnt_d = cnt_q + C_CNT_ONE;
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      pat_q  <= DEF_PAT;
      len_q  <= 5'(DEF_LEN);
      ovl_q  <= 1'b1;
      hist_q <= '0;
      fill_q <= 5'd0;
      z_q    <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      z_q    <= z_d;
      cnt_q  <= cnt_d;
    end
  end

  assign Z         = z_q;
  assign MATCH_CNT = cnt_q;
  assign CNT_SAT   = &cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_rec_param.sv
`default_nettype none
// Scoreboard bench for seq_rec_param: default 8-bit counter instance and a
// 2-bit counter instance share stimulus; expectations are queued per edge.
module tb_seq_rec_param;

  logic       clk;
  logic       n_reset;
  logic       x;
  logic       x_valid;
  logic       cfg_we;
  logic [7:0] cfg_pat;
  logic [4:0] cfg_len;
  logic       cfg_ovl;
  logic       cnt_clr;

  logic       z0, sat0, z1, sat1;
  logic [7:0] cnt0;
  logic [1:0] cnt1;

  seq_rec_param u_dut0 (
    .CLK(clk), .nRESET(n_reset), .X(x), .X_VALID(x_valid), .CFG_WE(cfg_we),
    .CFG_PAT(cfg_pat), .CFG_LEN(cfg_len), .CFG_OVL(cfg_ovl), .CNT_CLR(cnt_clr),
    .Z(z0), .MATCH_CNT(cnt0), .CNT_SAT(sat0)
  );

  seq_rec_param #(.CNT_W(2)) u_dut1 (
    .CLK(clk), .nRESET(n_reset), .X(x), .X_VALID(x_valid), .CFG_WE(cfg_we),
    .CFG_PAT(cfg_pat), .CFG_LEN(cfg_len), .CFG_OVL(cfg_ovl), .CNT_CLR(cnt_clr),
    .Z(z1), .MATCH_CNT(cnt1), .CNT_SAT(sat1)
  );

  typedef struct {
    logic       z;
    logic [7:0] c0;
    logic       s0;
    logic [1:0] c1;
    logic       s1;
  } exp_t;

  exp_t       sb_q[$];
  event       chk_now;
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] m0 = '0;
  logic [1:0] m1 = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic ez);
    exp_t e;
    e.z  = ez;
    e.c0 = m0;
    e.s0 = (m0 == 8'hFF);
    e.c1 = m1;
    e.s1 = (m1 == 2'b11);
    sb_q.push_back(e);
  endtask

  // Monitor: compares the oldest expectation against the DUT outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or chk_now);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("z0",   32'(z0),   32'(e.z));
        chk("z1",   32'(z1),   32'(e.z));
        chk("cnt0", 32'(cnt0), 32'(e.c0));
        chk("sat0", 32'(sat0), 32'(e.s0));
        chk("cnt1", 32'(cnt1), 32'(e.c1));
        chk("sat1", 32'(sat1), 32'(e.s1));
      end
    end
  end

  task automatic step(input logic bx, input logic v, input logic we,
                      input logic clr, input logic ez);
    x       = bx;
    x_valid = v;
    cfg_we  = we;
    cnt_clr = clr;
    @(posedge clk);
    #1;
    if (clr) begin
      m0 = ez ? 8'd1 : 8'd0;
      m1 = ez ? 2'd1 : 2'd0;
    end else if (ez) begin
      if (m0 != 8'hFF) m0 = m0 + 8'd1;
      if (m1 != 2'b11) m1 = m1 + 2'd1;
    end
    push_exp(ez);
    x_valid = 1'b0;
    cfg_we  = 1'b0;
    cnt_clr = 1'b0;
  endtask

  task automatic cfg(input logic [7:0] p, input logic [4:0] l, input logic o);
    cfg_pat = p;
    cfg_len = l;
    cfg_ovl = o;
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  // Sends bits[n-1] first; zs[i] is the expected Z after bits[i].
  task automatic stream(input logic [15:0] bits, input logic [15:0] zs, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      step(bits[i], 1'b1, 1'b0, 1'b0, zs[i]);
    end
  endtask

  // Reset asserted mid-cycle; outputs are checked before the next clock edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    n_reset = 1'b0;
    #1;
    m0 = '0;
    m1 = '0;
    push_exp(1'b0);
    -> chk_now;
    #1;
    n_reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    n_reset = 1'b0;
    x = 1'b0; x_valid = 1'b0; cfg_we = 1'b0; cnt_clr = 1'b0;
    cfg_pat = '0; cfg_len = '0; cfg_ovl = 1'b0;
    do_reset();

    // Default 101, overlapping
    stream(16'b1100110110101, 16'b0000000100101, 13);

    // Non-overlapping 101
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cfg(8'b00000101, 5'd3, 1'b0);
    stream(16'b1100110110101, 16'b0000000100100, 13);

    // 8-bit pattern with a 3-cycle valid gap
    cfg(8'b11010010, 5'd8, 1'b1);
    stream(16'b1101, 16'b0000, 4);
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    stream(16'b0010, 16'b0001, 4);

    // Saturation of the 2-bit counter, then clear on a match cycle
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cfg(8'b00000101, 5'd3, 1'b1);
    stream(16'b10101010101, 16'b00101010101, 11);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);

    // Reset in the middle of a partial match
    stream(16'b10, 16'b00, 2);
    do_reset();
    stream(16'b1101, 16'b0001, 4);

    // LEN 0 disables matching; LEN 20 clamps to 8
    cfg(8'b00000101, 5'd0, 1'b1);
    stream(16'b10101, 16'b00000, 5);
    cfg(8'b11010010, 5'd20, 1'b1);
    stream(16'b001011010010, 16'b000000000001, 12);

    repeat (3) @(negedge clk);
    #2;
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
